// File: rtl/axis_egress_packet_arbiter_pkg.sv
// Shared types and width helpers for the egress packet arbiter.
// The arbiter is either idle or moving one packet.
package axis_egress_packet_arbiter_pkg;

  localparam int DEF_NUM_INPUTS      = 4;
  localparam int DEF_AXIS_BUS_WIDTH  = 64;
  localparam int DEF_AXIS_ID_WIDTH   = 4;
  localparam int DEF_AXIS_DEST_WIDTH = 4;

  function automatic int grant_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int GRANT_W = grant_width(DEF_NUM_INPUTS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

endpackage

// File: rtl/axis_egress_packet_arbiter_if.sv
// Flattened multi-input AXI-Stream ingress plus single egress stream.
// The master view is the arbiter; the slave view is the surrounding producers and consumer.
interface axis_egress_packet_arbiter_if
  import axis_egress_packet_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS      = DEF_NUM_INPUTS,
  parameter int AXIS_BUS_WIDTH  = DEF_AXIS_BUS_WIDTH,
  parameter int AXIS_ID_WIDTH   = DEF_AXIS_ID_WIDTH,
  parameter int AXIS_DEST_WIDTH = DEF_AXIS_DEST_WIDTH
);
  logic [NUM_INPUTS*AXIS_BUS_WIDTH-1:0]     axis_in_tdata;
  logic [NUM_INPUTS*AXIS_BUS_WIDTH/8-1:0]   axis_in_tkeep;
  logic [NUM_INPUTS*AXIS_DEST_WIDTH-1:0]    axis_in_tdest;
  logic [NUM_INPUTS-1:0]                    axis_in_tlast;
  logic [NUM_INPUTS-1:0]                    axis_in_tvalid;
  logic [NUM_INPUTS-1:0]                    axis_in_tready;
  logic [AXIS_BUS_WIDTH-1:0]                axis_out_tdata;
  logic [AXIS_BUS_WIDTH/8-1:0]              axis_out_tkeep;
  logic [AXIS_ID_WIDTH-1:0]                 axis_out_tid;
  logic [AXIS_DEST_WIDTH-1:0]               axis_out_tdest;
  logic                                     axis_out_tlast;
  logic                                     axis_out_tvalid;
  logic                                     axis_out_tready;

  modport master (
    input  axis_in_tdata, axis_in_tkeep, axis_in_tdest, axis_in_tlast, axis_in_tvalid,
    output axis_in_tready,
    output axis_out_tdata, axis_out_tkeep, axis_out_tid, axis_out_tdest, axis_out_tlast,
    output axis_out_tvalid,
    input  axis_out_tready
  );

  modport slave (
    output axis_in_tdata, axis_in_tkeep, axis_in_tdest, axis_in_tlast, axis_in_tvalid,
    input  axis_in_tready,
    input  axis_out_tdata, axis_out_tkeep, axis_out_tid, axis_out_tdest, axis_out_tlast,
    input  axis_out_tvalid,
    output axis_out_tready
  );
endinterface

// File: rtl/axis_egress_packet_arbiter_rr_priority_picker.sv
// Round-robin pick: first requester found scanning last_grant+1, +2, ... modulo NUM_INPUTS.
module rr_priority_picker
  import axis_egress_packet_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int GNT_W      = grant_width(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [GNT_W-1:0]      last_grant,
  output logic                  found,
  output logic [GNT_W-1:0]      next_grant
);

  logic [GNT_W:0] cand_s;
  logic           hit_s;

  // Walk the ring once; the extra bit on cand_s lets the wrap be a plain subtract.
  always_comb begin
    found      = 1'b0;
    next_grant = last_grant;
    cand_s     = {(GNT_W+1){1'b0}};
    hit_s      = 1'b0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand_s = {1'b0, last_grant} + (GNT_W+1)'(k);
      cand_s = (cand_s >= (GNT_W+1)'(NUM_INPUTS)) ? cand_s - (GNT_W+1)'(NUM_INPUTS) : cand_s;
      hit_s      = req[cand_s[GNT_W-1:0]] & ~found;
      next_grant = hit_s ? cand_s[GNT_W-1:0] : next_grant;
      found      = found | hit_s;
    end
  end

endmodule

// File: rtl/axis_egress_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one egress AXI-Stream among NUM_INPUTS producers.
// A grant is held from first beat to tlast; the egress path is a pure mux with no storage.
module axis_egress_packet_arbiter
  import axis_egress_packet_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS      = DEF_NUM_INPUTS,
  parameter int AXIS_BUS_WIDTH  = DEF_AXIS_BUS_WIDTH,
  parameter int AXIS_ID_WIDTH   = DEF_AXIS_ID_WIDTH,
  parameter int AXIS_DEST_WIDTH = DEF_AXIS_DEST_WIDTH,
  localparam int GNT_W          = grant_width(NUM_INPUTS)
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  axis_egress_packet_arbiter_if.master         axis,
  input  logic [NUM_INPUTS-1:0]                port_enable,
  output logic [GNT_W-1:0]                     cur_grant,
  output logic                                 busy,
  output logic                                 pkt_done
);

  localparam int KEEP_W = AXIS_BUS_WIDTH / 8;

  if (NUM_INPUTS < 2 || NUM_INPUTS > 16) begin : g_bad_num_inputs
    $error("NUM_INPUTS must be within 2..16");
  end
  if (AXIS_ID_WIDTH < GNT_W) begin : g_bad_id_width
    $error("AXIS_ID_WIDTH too narrow to carry the input index");
  end
  if ((AXIS_BUS_WIDTH % 8) != 0) begin : g_bad_bus_width
    $error("AXIS_BUS_WIDTH must be a multiple of 8");
  end

  state_e                  state_r;
  logic [GNT_W-1:0]        cur_grant_r;
  logic                    pkt_done_r;
  logic [NUM_INPUTS-1:0]   req_s;
  logic                    found_s;
  logic [GNT_W-1:0]        pick_s;
  logic                    eop_hs_s;
  int                      sel_s;

  assign req_s    = axis.axis_in_tvalid & port_enable;
  assign sel_s    = int'(cur_grant_r);
  assign eop_hs_s = axis.axis_out_tvalid & axis.axis_out_tready & axis.axis_out_tlast;

  rr_priority_picker #(
    .NUM_INPUTS (NUM_INPUTS),
    .GNT_W      (GNT_W)
  ) u_picker (
    .req        (req_s),
    .last_grant (cur_grant_r),
    .found      (found_s),
    .next_grant (pick_s)
  );

  // Packet FSM: arbitrate in IDLE, hold the grant through XFER until the tlast handshake.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r     <= ST_IDLE;
      cur_grant_r <= GNT_W'(NUM_INPUTS - 1);
      pkt_done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          pkt_done_r <= 1'b0;
          if (found_s) begin
            cur_grant_r <= pick_s;
            state_r     <= ST_XFER;
          end
        end
        ST_XFER: begin
          pkt_done_r <= eop_hs_s;
          if (eop_hs_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          pkt_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Egress mux and ready steering; zero-latency so the first beat follows the grant cycle.
  always_comb begin
    axis.axis_out_tdata  = {AXIS_BUS_WIDTH{1'b0}};
    axis.axis_out_tkeep  = {KEEP_W{1'b0}};
    axis.axis_out_tdest  = {AXIS_DEST_WIDTH{1'b0}};
    axis.axis_out_tid    = {AXIS_ID_WIDTH{1'b0}};
    axis.axis_out_tlast  = 1'b0;
    axis.axis_out_tvalid = 1'b0;
    axis.axis_in_tready  = {NUM_INPUTS{1'b0}};
    if (state_r == ST_XFER) begin
      axis.axis_out_tdata  = axis.axis_in_tdata[sel_s*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
      axis.axis_out_tkeep  = axis.axis_in_tkeep[sel_s*KEEP_W +: KEEP_W];
      axis.axis_out_tdest  = axis.axis_in_tdest[sel_s*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH];
      axis.axis_out_tid    = AXIS_ID_WIDTH'(cur_grant_r);
      axis.axis_out_tlast  = axis.axis_in_tlast[cur_grant_r];
      axis.axis_out_tvalid = axis.axis_in_tvalid[cur_grant_r];
      axis.axis_in_tready[cur_grant_r] = axis.axis_out_tready;
    end else begin
      axis.axis_out_tid    = {AXIS_ID_WIDTH{1'b0}};
    end
  end

  assign cur_grant = cur_grant_r;
  assign busy      = (state_r == ST_XFER);
  assign pkt_done  = pkt_done_r;

endmodule

// File: tb/tb_axis_egress_packet_arbiter.sv
// Bench for the egress packet arbiter: directed scenarios, then random traffic
// compared cycle by cycle against a packet-level round-robin reference model.
module tb_axis_egress_packet_arbiter;
  import axis_egress_packet_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int KW = 8;
  localparam int IW = 4;
  localparam int DW = 4;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [N-1:0] port_enable = 4'b1111;
  logic [1:0]   cur_grant;
  logic         busy;
  logic         pkt_done;

  axis_egress_packet_arbiter_if #(.NUM_INPUTS(N), .AXIS_BUS_WIDTH(W),
    .AXIS_ID_WIDTH(IW), .AXIS_DEST_WIDTH(DW)) bus ();

  axis_egress_packet_arbiter #(.NUM_INPUTS(N), .AXIS_BUS_WIDTH(W),
    .AXIS_ID_WIDTH(IW), .AXIS_DEST_WIDTH(DW)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .axis        (bus),
    .port_enable (port_enable),
    .cur_grant   (cur_grant),
    .busy        (busy),
    .pkt_done    (pkt_done)
  );

  always #5 aclk = ~aclk;

  // producer sources
  bit          src_act [N];
  int          src_len [N];
  int          src_beat[N];
  logic [63:0] src_base[N];
  bit          src_rep [N];
  logic [7:0]  src_keep[N];
  logic [3:0]  src_dest[N];
  logic [N-1:0] drv_vld, drv_last;
  bit          drop_en = 1'b0;
  bit          rdy_rand = 1'b0;
  logic        tb_rdy = 1'b1;

  // reference model: owner = input holding the egress (-1 when none)
  int m_owner = -1;
  int m_last  = N - 1;
  bit m_done  = 1'b0;
  bit m_known = 1'b0;

  logic [63:0] out_data_q[$];
  int          out_tid_q[$];
  int          eop_tid_q[$];
  int          eop_cnt, done_cnt, cyc, first_beat_cyc;
  int          n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_pkt(input int i, input int len, input logic [63:0] base);
    src_act[i]  = 1'b1;
    src_len[i]  = len;
    src_beat[i] = 0;
    src_base[i] = base;
    src_keep[i] = 8'($urandom);
    src_dest[i] = 4'($urandom);
  endtask

  function automatic bit any_act();
    bit a = 1'b0;
    for (int i = 0; i < N; i++) a = a | src_act[i];
    return a;
  endfunction

  task automatic clear_logs();
    out_data_q.delete(); out_tid_q.delete(); eop_tid_q.delete();
    eop_cnt = 0; done_cnt = 0; first_beat_cyc = -1;
  endtask

  // One clock: drive at negedge, check against the model, then advance model and sources.
  task automatic step();
    logic [N-1:0] req, exp_rdy;
    logic         exp_vld;
    bit           found, eop;
    int           j;
    @(negedge aclk);
    for (int i = 0; i < N; i++) begin
      drv_vld[i]  = src_act[i] && !(drop_en && $urandom_range(0, 7) == 0);
      drv_last[i] = src_act[i] && (src_beat[i] == src_len[i] - 1);
      bus.axis_in_tvalid[i]          = drv_vld[i];
      bus.axis_in_tlast[i]           = drv_last[i];
      bus.axis_in_tdata[i*W +: W]    = src_base[i] + 64'(src_beat[i]);
      bus.axis_in_tkeep[i*KW +: KW]  = src_keep[i];
      bus.axis_in_tdest[i*DW +: DW]  = src_dest[i];
    end
    bus.axis_out_tready = rdy_rand ? 1'($urandom) : tb_rdy;
    #1;
    cyc++;
    if (m_known) begin
      exp_rdy = (m_owner >= 0) ? (N'(bus.axis_out_tready) << m_owner) : 4'b0000;
      exp_vld = (m_owner >= 0) ? drv_vld[m_owner] : 1'b0;
      check("busy", busy, (m_owner >= 0));
      check("cur_grant", cur_grant, m_last);
      check("pkt_done", pkt_done, m_done);
      check("in_tready", bus.axis_in_tready, exp_rdy);
      check("out_tvalid", bus.axis_out_tvalid, exp_vld);
      if (exp_vld) begin
        check("out_tdata", bus.axis_out_tdata, src_base[m_owner] + 64'(src_beat[m_owner]));
        check("out_tkeep", bus.axis_out_tkeep, src_keep[m_owner]);
        check("out_tdest", bus.axis_out_tdest, src_dest[m_owner]);
        check("out_tlast", bus.axis_out_tlast, drv_last[m_owner]);
        check("out_tid", bus.axis_out_tid, m_owner);
      end
    end
    if (bus.axis_out_tvalid === 1'b1 && bus.axis_out_tready) begin
      if (out_data_q.size() == 0) first_beat_cyc = cyc;
      out_data_q.push_back(bus.axis_out_tdata);
      out_tid_q.push_back(int'(bus.axis_out_tid));
      if (bus.axis_out_tlast === 1'b1) begin
        eop_cnt++;
        eop_tid_q.push_back(int'(bus.axis_out_tid));
      end
    end
    if (pkt_done === 1'b1) done_cnt++;
    req = drv_vld & port_enable;
    if (!aresetn) begin
      m_owner = -1; m_last = N - 1; m_done = 1'b0; m_known = 1'b1;
    end else if (m_owner < 0) begin
      m_done = 1'b0;
      found  = 1'b0;
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (!found && req[j]) begin
          found = 1'b1; m_owner = j; m_last = j;
        end
      end
    end else begin
      eop = drv_vld[m_owner] && bus.axis_out_tready && drv_last[m_owner];
      m_done = eop;
      if (eop) m_owner = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (src_act[i] && drv_vld[i] && bus.axis_in_tready[i] === 1'b1) begin
        src_beat[i]++;
        if (src_beat[i] == src_len[i]) begin
          if (src_rep[i]) begin
            src_beat[i] = 0;
            src_base[i] = src_base[i] + 64'h100;
          end else begin
            src_act[i] = 1'b0;
          end
        end
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) src_rep[i] = 1'b0;
    for (int c = 0; c < 200 && any_act(); c++) step();
    check("drain_done", any_act(), 0);
  endtask

  initial begin
    int c, n0, n1, n3, cyc0;
    for (int i = 0; i < N; i++) begin
      src_act[i] = 1'b0; src_rep[i] = 1'b0; src_len[i] = 1; src_beat[i] = 0;
      src_base[i] = 64'h0; src_keep[i] = 8'h00; src_dest[i] = 4'h0;
    end
    bus.axis_in_tvalid = 4'b0000;
    bus.axis_out_tready = 1'b1;
    cyc = 0;
    clear_logs();

    // reset state
    do_reset();
    check("rst_tvalid", bus.axis_out_tvalid, 0);
    check("rst_tready", bus.axis_in_tready, 0);
    check("rst_grant", cur_grant, 3);
    check("rst_busy", busy, 0);
    check("rst_done", pkt_done, 0);

    // 1: single 3-beat packet from in0
    clear_logs();
    tb_rdy = 1'b1;
    cyc0 = cyc;
    start_pkt(0, 3, 64'hA1);
    for (int s = 0; s < 6; s++) step();
    check("t1_beats", out_data_q.size(), 3);
    for (int b = 0; b < 3 && b < out_data_q.size(); b++) begin
      check("t1_data", out_data_q[b], 64'hA1 + 64'(b));
      check("t1_tid", out_tid_q[b], 0);
    end
    check("t1_first_beat_cycle", first_beat_cyc, cyc0 + 2);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_busy_after", busy, 0);

    // 2: fairness, all inputs continuously offering 2-beat packets
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) begin
      src_rep[i] = 1'b1;
      start_pkt(i, 2, 64'(i) << 32);
    end
    c = 0;
    while (eop_cnt < 12 && c < 100) begin
      step();
      c++;
    end
    check("t2_cycles_for_12", c, 36);
    for (int p = 0; p < 12 && p < eop_tid_q.size(); p++) check("t2_grant_order", eop_tid_q[p], p % 4);
    drain();

    // 3: backpressure on a 4-beat packet from in2
    do_reset();
    clear_logs();
    tb_rdy = 1'b1;
    start_pkt(2, 4, 64'h300);
    step();
    for (int k = 0; k < 7; k++) begin
      tb_rdy = (k % 2 == 0);
      step();
    end
    tb_rdy = 1'b1;
    check("t3_beats", out_data_q.size(), 4);
    for (int b = 0; b < 4 && b < out_data_q.size(); b++) check("t3_data", out_data_q[b], 64'h300 + 64'(b));
    check("t3_busy_after", busy, 0);
    drain();

    // 4: enable mask, then fence in0 mid-packet
    do_reset();
    clear_logs();
    port_enable = 4'b1101;
    for (int i = 0; i < N; i++) begin
      src_rep[i] = 1'b1;
      start_pkt(i, 2, 64'(i) << 32);
    end
    step();
    step();
    check("t4_first_grant", cur_grant, 0);
    port_enable = 4'b1100;
    step();
    step();
    check("t4_next_grant", cur_grant, 2);
    check("t4_in0_finished", out_tid_q.size() >= 2 && out_tid_q[1] == 0, 1);
    port_enable = 4'b1101;
    clear_logs();
    for (int s = 0; s < 40; s++) step();
    n0 = 0; n1 = 0;
    foreach (out_tid_q[b]) begin
      if (out_tid_q[b] == 0) n0++;
      if (out_tid_q[b] == 1) n1++;
    end
    check("t4_in1_never", n1, 0);
    check("t4_in0_served", n0 > 0, 1);
    port_enable = 4'b1111;
    drain();

    // 5: reset on beat 2 of a 5-beat packet from in3
    do_reset();
    clear_logs();
    tb_rdy = 1'b1;
    start_pkt(3, 5, 64'h500);
    step();
    step();
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    src_act[3] = 1'b0;
    check("t5_tvalid", bus.axis_out_tvalid, 0);
    check("t5_tready", bus.axis_in_tready, 0);
    check("t5_grant", cur_grant, 3);
    check("t5_busy", busy, 0);
    start_pkt(0, 1, 64'h5A0);
    start_pkt(3, 1, 64'h5B0);
    step();
    check("t5_regrant", cur_grant, 0);
    check("t5_regrant_tid", bus.axis_out_tid, 0);
    drain();

    // 6: wrap-around with single-beat packets from in3 only
    do_reset();
    clear_logs();
    src_rep[3] = 1'b1;
    start_pkt(3, 1, 64'h600);
    for (int s = 0; s < 20; s++) step();
    check("t6_packets", eop_cnt, 10);
    n3 = 0;
    foreach (eop_tid_q[p]) if (eop_tid_q[p] == 3) n3++;
    check("t6_all_in3", n3, eop_cnt);
    drain();

    // random traffic against the model
    do_reset();
    drop_en  = 1'b1;
    rdy_rand = 1'b1;
    for (int r = 0; r < 3000; r++) begin
      for (int i = 0; i < N; i++)
        if (!src_act[i] && $urandom_range(0, 3) == 0)
          start_pkt(i, $urandom_range(1, 4), {$urandom, $urandom});
      if ($urandom_range(0, 19) == 0) port_enable = 4'($urandom);
      aresetn = ($urandom_range(0, 199) != 0);
      step();
    end
    aresetn     = 1'b1;
    drop_en     = 1'b0;
    port_enable = 4'b1111;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
